// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } fetch_state_e;

    localparam logic [15:0] PC_RESET_DEFAULT = 16'h0000;
    localparam logic [15:0] BUBBLE_INSTR     = 16'h0000;
    localparam int          PC_INCR          = 2;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
//   clk   : clock
//   clear : synchronous clear (active high)
//   inc   : increment request, ignored once the counter is all-ones
//   count : current count
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: PC, imem handshake, IF/ID register
//   clk, rst                  : clock, synchronous active-high reset
//   stall                     : hold PC and IF/ID contents
//   branch_taken/target       : redirect PC, flush IF/ID
//   hlt_decoded               : HLT seen in ID; halts when IF/ID is valid
//   imem_req/addr             : request strobe and address (= PC)
//   imem_data/valid           : returned instruction
//   if_id_instr/pc_plus2/valid: pipeline register towards the decoder
//   halted, pc_out            : status / debug
//   fetch_cnt, stall_cnt      : performance counters, only with FETCH_PERF_EN
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(PC_RESET_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               hlt_decoded,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               imem_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc_plus2,
    output logic               if_id_valid,
    output logic               halted,
    output logic [ADDR_W-1:0]  pc_out
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        fetch_cnt,
    output logic [15:0]        stall_cnt
`endif
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               squash_q, squash_d;
    logic [INSTR_W-1:0] hold_q, hold_d;
    logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
    logic [ADDR_W-1:0]  if_id_pc_plus2_q, if_id_pc_plus2_d;
    logic               if_id_valid_q, if_id_valid_d;
    logic               halted_q, halted_d;

    logic               halt_cond;
    logic               load_en;
    logic [INSTR_W-1:0] load_instr;
    logic [ADDR_W-1:0]  pc_plus2;

    assign halt_cond = hlt_decoded & if_id_valid_q;
    assign pc_plus2  = pc_q + ADDR_W'(PC_INCR);
    assign imem_req  = (state_q == FETCH) & ~branch_taken & ~halt_cond;
    assign imem_addr = pc_q;

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        squash_d         = squash_q;
        hold_d           = hold_q;
        halted_d         = halted_q;
        load_en          = 1'b0;
        load_instr       = hold_q;
        if_id_instr_d    = if_id_instr_q;
        if_id_pc_plus2_d = if_id_pc_plus2_q;
        if_id_valid_d    = if_id_valid_q;

        if (state_q == HALTED) begin
            // frozen until reset
        end else if (halt_cond) begin
            // any in-flight response is simply never sampled again
            state_d  = HALTED;
            halted_d = 1'b1;
            squash_d = 1'b0;
        end else if (branch_taken) begin
            pc_d = branch_target;
            if ((state_q == WAIT) && !imem_valid) begin
                // response for the old PC still outstanding: drop it on arrival
                squash_d = 1'b1;
            end else begin
                // nothing outstanding (or it is arriving now and gets dropped)
                squash_d = 1'b0;
                state_d  = FETCH;
            end
        end else begin
            case (state_q)
                FETCH: state_d = WAIT;
                WAIT: begin
                    if (imem_valid) begin
                        if (squash_q) begin
                            squash_d = 1'b0;
                            state_d  = FETCH;
                        end else if (stall) begin
                            hold_d  = imem_data;
                            state_d = HOLD;
                        end else begin
                            load_en    = 1'b1;
                            load_instr = imem_data;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        load_en = 1'b1;
                    end
                end
                default: ;
            endcase
            if (load_en) begin
                pc_d    = pc_plus2;
                state_d = FETCH;
            end
        end

        // IF/ID: load > flush (halt/branch) > stall hold > bubble
        if (load_en) begin
            if_id_instr_d    = load_instr;
            if_id_pc_plus2_d = pc_plus2;
            if_id_valid_d    = 1'b1;
        end else if (halt_cond || branch_taken) begin
            if_id_valid_d = 1'b0;
        end else if (!stall) begin
            if_id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= FETCH;
            pc_q             <= PC_RESET;
            squash_q         <= 1'b0;
            hold_q           <= INSTR_W'(BUBBLE_INSTR);
            if_id_instr_q    <= INSTR_W'(BUBBLE_INSTR);
            if_id_pc_plus2_q <= '0;
            if_id_valid_q    <= 1'b0;
            halted_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            squash_q         <= squash_d;
            hold_q           <= hold_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_pc_plus2_q <= if_id_pc_plus2_d;
            if_id_valid_q    <= if_id_valid_d;
            halted_q         <= halted_d;
        end
    end

    assign if_id_instr    = if_id_instr_q;
    assign if_id_pc_plus2 = if_id_pc_plus2_q;
    assign if_id_valid    = if_id_valid_q;
    assign halted         = halted_q;
    assign pc_out         = pc_q;

`ifdef FETCH_PERF_EN
    sat_counter #(.WIDTH(16)) u_fetch_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (load_en),
        .count (fetch_cnt)
    );

    sat_counter #(.WIDTH(16)) u_stall_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (stall & (state_q != HALTED)),
        .count (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        hlt_decoded = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_data = 16'h0000;
    logic        imem_valid = 1'b0;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        halted;
    logic [15:0] pc_out;
`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt;
    logic [15:0] stall_cnt;
`endif

    fetch_unit #(.ADDR_W(16), .INSTR_W(16), .PC_RESET(16'h0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .hlt_decoded    (hlt_decoded),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .imem_valid     (imem_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus2 (if_id_pc_plus2),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .pc_out         (pc_out)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt      (fetch_cnt),
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic        hlt;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic        exp_valid;
        logic [15:0] exp_pc;
        logic        exp_halted;
        logic        chk_instr;
        logic [15:0] exp_instr;
    } vec_t;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc2;
    } exp_t;

    exp_t        sbq[$];
    vec_t        tbl[11];
    int          total = 0;
    int          bad = 0;
    int          mem_lat = 1;
    int          lat_cnt = 0;
    logic [15:0] pend_addr = 16'h0000;
    logic        push_en = 1'b0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'hB123;
        if (a == 16'h0102) return 16'h0456;
        return {a[7:0] ^ 8'h3C, a[15:8] ^ 8'hC3};
    endfunction

    function automatic vec_t v(input logic s, input logic b, input logic [15:0] t, input logic h,
                               input logic er, input logic [15:0] ea, input logic ev,
                               input logic [15:0] ep, input logic eh, input logic ci,
                               input logic [15:0] ei);
        vec_t r;
        r.stall = s; r.br = b; r.tgt = t; r.hlt = h;
        r.exp_req = er; r.exp_addr = ea; r.exp_valid = ev; r.exp_pc = ep;
        r.exp_halted = eh; r.chk_instr = ci; r.exp_instr = ei;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One clock: memory model answers each request mem_lat cycles later;
    // the scoreboard is popped whenever IF/ID takes a fresh instruction.
    task automatic tick();
        logic        req_s;
        logic        stall_s;
        logic [15:0] addr_s;
        exp_t        e;
        #1;
        req_s   = imem_req;
        addr_s  = imem_addr;
        stall_s = stall;
        @(posedge clk);
        #1;
        imem_valid = 1'b0;
        if (req_s === 1'b1) begin
            lat_cnt   = mem_lat;
            pend_addr = addr_s;
            if (push_en) sbq.push_back('{mem_word(addr_s), addr_s + 16'd2});
        end
        if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
                imem_valid = 1'b1;
                imem_data  = mem_word(pend_addr);
            end
        end
        if (if_id_valid === 1'b1 && !stall_s) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: load of %h with nothing expected", if_id_instr);
            end else begin
                e = sbq.pop_front();
                chk("sb_instr", {16'h0, if_id_instr}, {16'h0, e.instr});
                chk("sb_pc2", {16'h0, if_id_pc_plus2}, {16'h0, e.pc2});
            end
        end
    endtask

    task automatic apply_row(input vec_t r, input string nm);
        stall         = r.stall;
        branch_taken  = r.br;
        branch_target = r.tgt;
        hlt_decoded   = r.hlt;
        #1;
        chk({nm, "_req"}, {31'h0, imem_req}, {31'h0, r.exp_req});
        chk({nm, "_addr"}, {16'h0, imem_addr}, {16'h0, r.exp_addr});
        tick();
        chk({nm, "_valid"}, {31'h0, if_id_valid}, {31'h0, r.exp_valid});
        chk({nm, "_pc"}, {16'h0, pc_out}, {16'h0, r.exp_pc});
        chk({nm, "_halted"}, {31'h0, halted}, {31'h0, r.exp_halted});
        if (r.chk_instr) chk({nm, "_instr"}, {16'h0, if_id_instr}, {16'h0, r.exp_instr});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // streaming fetch, branch from FETCH, then stall across a response
        tbl[0]  = v(0, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000);
        tbl[1]  = v(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0002, 0, 1, 16'hB123);
        tbl[2]  = v(0, 0, 16'h0000, 0, 1, 16'h0002, 0, 16'h0002, 0, 0, 16'h0000);
        tbl[3]  = v(0, 0, 16'h0000, 0, 0, 16'h0002, 1, 16'h0004, 0, 1, mem_word(16'h0002));
        tbl[4]  = v(0, 1, 16'h0100, 0, 0, 16'h0004, 0, 16'h0100, 0, 0, 16'h0000);
        tbl[5]  = v(0, 0, 16'h0000, 0, 1, 16'h0100, 0, 16'h0100, 0, 0, 16'h0000);
        tbl[6]  = v(0, 0, 16'h0000, 0, 0, 16'h0100, 1, 16'h0102, 0, 1, mem_word(16'h0100));
        tbl[7]  = v(1, 0, 16'h0000, 0, 1, 16'h0102, 1, 16'h0102, 0, 1, mem_word(16'h0100));
        tbl[8]  = v(1, 0, 16'h0000, 0, 0, 16'h0102, 1, 16'h0102, 0, 1, mem_word(16'h0100));
        tbl[9]  = v(1, 0, 16'h0000, 0, 0, 16'h0102, 1, 16'h0102, 0, 1, mem_word(16'h0100));
        tbl[10] = v(0, 0, 16'h0000, 0, 0, 16'h0102, 1, 16'h0104, 0, 1, 16'h0456);

        // reset; the request made during reset returns late and must be ignored
        tick();
        tick();
        rst = 1'b0;
        chk("rst_pc", {16'h0, pc_out}, 32'h0);
        chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
        chk("rst_instr", {16'h0, if_id_instr}, 32'h0);
        chk("rst_pc2", {16'h0, if_id_pc_plus2}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);

        push_en = 1'b1;
        for (int i = 0; i < 11; i++) apply_row(tbl[i], $sformatf("t%0d", i));
`ifdef FETCH_PERF_EN
        chk("perf_fetch", {16'h0, fetch_cnt}, 32'd4);
        chk("perf_stall", {16'h0, stall_cnt}, 32'd3);
`endif

        // branch in WAIT, slow memory: response squashed
        push_en = 1'b0;
        mem_lat = 2;
        apply_row(v(0, 0, 16'h0000, 0, 1, 16'h0104, 0, 16'h0104, 0, 0, 16'h0), "B1");
        apply_row(v(0, 1, 16'h0040, 0, 0, 16'h0104, 0, 16'h0040, 0, 0, 16'h0), "B2");
        apply_row(v(0, 0, 16'h0000, 0, 0, 16'h0040, 0, 16'h0040, 0, 0, 16'h0), "B3");
        mem_lat = 1;
        push_en = 1'b1;
        apply_row(v(0, 0, 16'h0000, 0, 1, 16'h0040, 0, 16'h0040, 0, 0, 16'h0), "B4");
        apply_row(v(0, 0, 16'h0000, 0, 0, 16'h0040, 1, 16'h0042, 0, 1, mem_word(16'h0040)), "B5");

        // branch and stall together while holding a response: flush wins
        push_en = 1'b0;
        apply_row(v(1, 0, 16'h0000, 0, 1, 16'h0042, 1, 16'h0042, 0, 1, mem_word(16'h0040)), "C1");
        apply_row(v(1, 0, 16'h0000, 0, 0, 16'h0042, 1, 16'h0042, 0, 1, mem_word(16'h0040)), "C2");
        apply_row(v(1, 1, 16'h0200, 0, 0, 16'h0042, 0, 16'h0200, 0, 0, 16'h0), "C3");
        push_en = 1'b1;
        apply_row(v(0, 0, 16'h0000, 0, 1, 16'h0200, 0, 16'h0200, 0, 0, 16'h0), "C4");
        apply_row(v(0, 0, 16'h0000, 0, 0, 16'h0200, 1, 16'h0202, 0, 1, mem_word(16'h0200)), "C5");

        // HLT with valid IF/ID while a response arrives; halt beats branch
        push_en = 1'b0;
        apply_row(v(1, 0, 16'h0000, 0, 1, 16'h0202, 1, 16'h0202, 0, 1, mem_word(16'h0200)), "D1");
        apply_row(v(0, 1, 16'h0300, 1, 0, 16'h0202, 0, 16'h0202, 1, 0, 16'h0), "D2");
        apply_row(v(0, 1, 16'h0300, 0, 0, 16'h0202, 0, 16'h0202, 1, 0, 16'h0), "D3");
        for (int i = 0; i < 3; i++)
            apply_row(v(0, 0, 16'h0000, 0, 0, 16'h0202, 0, 16'h0202, 1, 0, 16'h0), $sformatf("D4_%0d", i));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("D5_pc", {16'h0, pc_out}, 32'h0);
        chk("D5_halted", {31'h0, halted}, 32'h0);
        chk("D5_valid", {31'h0, if_id_valid}, 32'h0);

        // PC wrap at the top of the address space
        push_en = 1'b1;
        apply_row(v(0, 1, 16'hFFFE, 0, 0, 16'h0000, 0, 16'hFFFE, 0, 0, 16'h0), "E1");
        apply_row(v(0, 0, 16'h0000, 0, 1, 16'hFFFE, 0, 16'hFFFE, 0, 0, 16'h0), "E2");
        apply_row(v(0, 0, 16'h0000, 0, 0, 16'hFFFE, 1, 16'h0000, 0, 1, mem_word(16'hFFFE)), "E3");
        chk("E3_pc2", {16'h0, if_id_pc_plus2}, 32'h0);
        apply_row(v(0, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 0, 0, 16'h0), "E4");
        apply_row(v(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0002, 0, 1, 16'hB123), "E5");
`ifdef FETCH_PERF_EN
        chk("perf_fetch_end", {16'h0, fetch_cnt}, 32'd2);
        chk("perf_stall_end", {16'h0, stall_cnt}, 32'd0);
`endif

        chk("sb_drain", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the opcode decoder/control unit in the 16-bit pipelined core.
- Owns the PC and the instruction-memory request handshake (at most one outstanding request).
- Owns the IF/ID pipeline register.
- Applies stall, branch flush and HLT from ID, so the decoder always sees either a valid instruction or a marked bubble.

Parameters:
ADDR_W, 16, PC and instruction-memory address width
INSTR_W, 16, instruction width
PC_RESET, 16'h0000, PC value loaded on reset

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
stall  in  1  hazard unit: hold PC and IF/ID contents
branch_taken  in  1  ID resolved a taken B/BR this cycle
branch_target  in  ADDR_W  redirect PC, valid with branch_taken
hlt_decoded  in  1  control unit decoded HLT in ID
imem_req  out  1  request strobe (combinational from state)
imem_addr  out  ADDR_W  request address, equal to PC
imem_data  in  INSTR_W  returned instruction
imem_valid  in  1  imem_data valid (≥1 cycle after imem_req)
if_id_instr  out  INSTR_W  instruction to the decoder
if_id_pc_plus2  out  ADDR_W  PC+2 of that instruction (used by PCS/B/BR)
if_id_valid  out  1  IF/ID holds a real instruction
halted  out  1  core halted
pc_out  out  ADDR_W  current PC (debug)

Behaviour:
- Reset (rst=1 at posedge, any state):
  - PC=PC_RESET, state=FETCH.
  - if_id_instr=0, if_id_pc_plus2=0, if_id_valid=0, halted=0.
  - A late imem_valid after reset is ignored; imem_valid is only sampled in WAIT.
- States: FETCH, WAIT, HOLD, HALTED.
- imem_req = (state==FETCH) & ~branch_taken & ~halt_cond, where halt_cond = hlt_decoded & if_id_valid. imem_addr = PC.
- FETCH:
  - If branch_taken: PC<=branch_target, stay in FETCH.
  - Otherwise issue the request and go to WAIT.
- WAIT:
  - branch_taken while waiting: PC<=branch_target and set squash.
  - On imem_valid with squash=1: discard the data, clear squash, go to FETCH.
  - On imem_valid with stall=1: capture the data in the hold register, go to HOLD.
  - On imem_valid otherwise: IF/ID<={imem_data, PC+2, 1}, PC<=PC+2, go to FETCH.
- HOLD:
  - branch_taken: discard the held data, PC<=branch_target, go to FETCH.
  - ~stall: IF/ID<={held, PC+2, 1}, PC<=PC+2, go to FETCH.
- HALTED: no requests, PC frozen, halted=1. Only rst exits.
- IF/ID register:
  - stall=1 holds all fields.
  - branch_taken forces if_id_valid<=0 and takes priority over stall.
  - A cycle with no instruction load and no stall gives if_id_valid<=0 (bubble).
- HLT: halt_cond from any state → HALTED next cycle.
  - Any in-flight response is ignored.
  - if_id_valid<=0.
  - halt_cond has priority over branch_taken.
- Arithmetic: PC+2 is modulo 2^ADDR_W, so 16'hFFFE+2=16'h0000. branch_target is used unmodified.
- Throughput: with 1-cycle memory latency, one instruction every 2 cycles.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs fetch_cnt[15:0] and stall_cnt[15:0].
  - fetch_cnt increments on every IF/ID load with valid=1.
  - stall_cnt increments every cycle with stall=1 while not HALTED.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: neither port nor counter exists, and all other behaviour is identical.

Decomposition:
- Package fetch_pkg: state enum (FETCH, WAIT, HOLD, HALTED), PC_RESET default, BUBBLE_INSTR=16'h0000, PC_INCR=2.
- Sub-module sat_counter (16-bit, inc/clear, saturating), instantiated twice under FETCH_PERF_EN.

Test Plan:
- Reset then 1-cycle memory returning 16'hB123 at addr 0 → imem_addr 0; if_id_instr=16'hB123, if_id_pc_plus2=2, if_id_valid=1 two cycles after reset release; PC=2.
- Stall held 3 cycles while response 16'h0456 returns → HOLD entered; IF/ID unchanged during stall; 16'h0456 loaded the cycle after stall drops.
- branch_taken with target 16'h0040 in WAIT → response discarded, if_id_valid=0, next imem_addr=16'h0040.
- branch_taken and stall in the same cycle → if_id_valid=0 (flush wins), PC=target.
- hlt_decoded with if_id_valid=1, then response arrives → halted=1 next cycle, imem_req stays 0, PC frozen, IF/ID valid=0; rst restores PC=0.
- PC=16'hFFFE fetch → if_id_pc_plus2=16'h0000, next imem_addr=16'h0000.
